// File: rtl/input_buffer_ctrl_if.sv
// input_buffer_ctrl_if: buffer read port, downstream window strobes and frame control.
// Carries o_err only when INPUT_BUFFER_CTRL_ERR_EN is defined.
interface input_buffer_ctrl_if #(
  parameter int FF_ADDR_WIDTH = 3,
  parameter int ROW_WIDTH     = 8
);
  logic [ROW_WIDTH-1:0]   cfg_row_len;
  logic [ROW_WIDTH-1:0]   cfg_num_rows;
  logic                   start;
  logic                   ds_ready;
  logic [FF_ADDR_WIDTH:0] buf_data_counter;
  logic                   buf_data_vld;
  logic                   buf_rd_req;
  logic                   o_win_vld;
  logic                   o_row_last;
  logic                   o_frame_done;
  logic                   o_busy;
`ifdef INPUT_BUFFER_CTRL_ERR_EN
  logic                   o_err;

  modport master (
    input  cfg_row_len, cfg_num_rows, start, ds_ready,
    input  buf_data_counter, buf_data_vld,
    output buf_rd_req, o_win_vld, o_row_last,
    output o_frame_done, o_busy, o_err
  );

  modport slave (
    output cfg_row_len, cfg_num_rows, start, ds_ready,
    output buf_data_counter, buf_data_vld,
    input  buf_rd_req, o_win_vld, o_row_last,
    input  o_frame_done, o_busy, o_err
  );
`else
  modport master (
    input  cfg_row_len, cfg_num_rows, start, ds_ready,
    input  buf_data_counter, buf_data_vld,
    output buf_rd_req, o_win_vld, o_row_last,
    output o_frame_done, o_busy
  );

  modport slave (
    output cfg_row_len, cfg_num_rows, start, ds_ready,
    output buf_data_counter, buf_data_vld,
    input  buf_rd_req, o_win_vld, o_row_last,
    input  o_frame_done, o_busy
  );
`endif
endinterface

// File: rtl/input_buffer_ctrl.sv
// input_buffer_ctrl: row-by-row sliding-window read scheduler for the input buffer.
// Optional sticky error flag via INPUT_BUFFER_CTRL_ERR_EN.
module input_buffer_ctrl #(
  parameter int NUM_RDATA     = 3,
  parameter int FF_ADDR_WIDTH = 3,
  parameter int ROW_WIDTH     = 8
) (
  input logic                 clk,
  input logic                 rst,
  input_buffer_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  localparam int FW = (NUM_RDATA > 2) ? $clog2(NUM_RDATA) : 1;
  localparam int CW = FF_ADDR_WIDTH + 2;

  state_t               state_q;
  logic [ROW_WIDTH-1:0] len_q;
  logic [ROW_WIDTH-1:0] rows_q;
  logic [ROW_WIDTH-1:0] pos_q;
  logic [ROW_WIDTH-1:0] row_q;
  logic [FW-1:0]        fl_q;
  logic                 req_q;
  logic                 discard_q;
  logic                 row_last_q;
  logic                 busy_q;
  logic                 done_q;

  logic [CW-1:0] occ;
  logic          run_ok;
  logic          flush_ok;
  logic          last_pos;
  logic          last_fl;
  logic          last_row;
  logic          cfg_bad;
  logic          req;
  logic          rd_req;

  // Occupancy checks fold the previous request in on the right-hand
  // side, so eff = counter - req_q never underflows.
  always_comb begin
    occ      = CW'(bus.buf_data_counter);
    run_ok   = occ >= (CW'(NUM_RDATA) + CW'(req_q));
    flush_ok = occ >= (CW'(1) + CW'(req_q));
    last_pos = pos_q == (len_q - ROW_WIDTH'(NUM_RDATA));
    last_fl  = fl_q == FW'(NUM_RDATA - 2);
    last_row = row_q == (rows_q - ROW_WIDTH'(1));
    cfg_bad  = (bus.cfg_row_len < ROW_WIDTH'(NUM_RDATA)) ||
               (bus.cfg_num_rows == '0);
  end

  // Read request: windows need a full window and downstream room,
  // flush discards only need one entry and ignore downstream.
  always_comb begin
    req = 1'b0;
    case (state_q)
      RUN:     req = run_ok & bus.ds_ready;
      FLUSH:   req = flush_ok;
      default: req = 1'b0;
    endcase
    rd_req = req & ~rst;
  end

  assign bus.buf_rd_req   = rd_req;
  assign bus.o_win_vld    = bus.buf_data_vld & req_q & ~discard_q;
  assign bus.o_row_last   = bus.buf_data_vld & req_q & ~discard_q &
                            row_last_q;
  assign bus.o_frame_done = done_q;
  assign bus.o_busy       = busy_q;

  // Frame FSM, position/row/flush counters and the read-tag pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      rows_q     <= '0;
      pos_q      <= '0;
      row_q      <= '0;
      fl_q       <= '0;
      req_q      <= 1'b0;
      discard_q  <= 1'b0;
      row_last_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      req_q      <= rd_req;
      discard_q  <= rd_req & (state_q == FLUSH);
      row_last_q <= rd_req & (state_q == RUN) & last_pos;
      done_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start && !cfg_bad) begin
            len_q   <= bus.cfg_row_len;
            rows_q  <= bus.cfg_num_rows;
            pos_q   <= '0;
            row_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (rd_req) begin
            if (last_pos) begin
              fl_q    <= '0;
              state_q <= FLUSH;
            end else begin
              pos_q <= pos_q + ROW_WIDTH'(1);
            end
          end
        end
        FLUSH: begin
          if (rd_req) begin
            fl_q <= fl_q + FW'(1);
            if (last_fl) begin
              if (last_row) begin
                done_q  <= 1'b1;
                state_q <= DONE;
              end else begin
                row_q   <= row_q + ROW_WIDTH'(1);
                pos_q   <= '0;
                state_q <= RUN;
              end
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef INPUT_BUFFER_CTRL_ERR_EN
  logic err_q;

  // Sticky protocol error: orphan read data, start while busy, bad config.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((bus.buf_data_vld && !req_q) ||
                 (bus.start && state_q != IDLE) ||
                 (bus.start && state_q == IDLE && cfg_bad)) begin
      err_q <= 1'b1;
    end
  end

  assign bus.o_err = err_q;
`endif

endmodule

// File: doc/input_buffer_ctrl.md
# input_buffer_ctrl

Read scheduler for the activation input buffer. It sequences `NUM_RDATA`-wide sliding-window reads row by row over a configured frame (stride 1). At each row end it flushes the stale tail entries and signals row and frame boundaries to the PE array. It sits between the input buffer's read port and the downstream compute stage, and is the only agent driving the buffer's read request.

## Interface
Parameters:
- `NUM_RDATA`, 3, window size (positions returned per read)
- `FF_ADDR_WIDTH`, 3, buffer address width; the occupancy port is `FF_ADDR_WIDTH+1` bits
- `ROW_WIDTH`, 8, width of the row-length and row-count config fields

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `cfg_row_len`  in  `ROW_WIDTH`  positions per input row (W); sampled on `start`
- `cfg_num_rows`  in  `ROW_WIDTH`  rows per frame (H); sampled on `start`
- `start`  in  1  one-cycle pulse; begins a frame when idle
- `ds_ready`  in  1  downstream can accept a window next cycle
- `buf_data_counter`  in  `FF_ADDR_WIDTH+1`  buffer occupancy
- `buf_data_vld`  in  1  buffer read-data valid
- `buf_rd_req`  out  1  buffer read request (pop one entry, present `NUM_RDATA`)
- `o_win_vld`  out  1  window valid to downstream (`buf_data_vld` with flush reads masked)
- `o_row_last`  out  1  qualifies `o_win_vld`; last window of a row
- `o_frame_done`  out  1  one-cycle pulse after the last flush of the last row
- `o_busy`  out  1  high from `start` acceptance until `o_frame_done`

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: `start`=1 latches the config, clears the position counter `pos` and row counter `row`, and moves to RUN. A config with `cfg_row_len < NUM_RDATA` or `cfg_num_rows==0` is rejected: the block stays in IDLE.
- Effective occupancy `eff = buf_data_counter − buf_rd_req` (registered previous-cycle request). This accounts for the one-cycle counter update lag.
- RUN: issue `buf_rd_req` when `eff >= NUM_RDATA` and `ds_ready`. Each request increments `pos`.
  - When the request with `pos == cfg_row_len − NUM_RDATA` issues, tag it row-last and go to FLUSH.
- FLUSH: issue `NUM_RDATA−1` discard requests, one per cycle while `eff >= 1`. `ds_ready` is ignored.
  - After the final discard: if `row == cfg_num_rows−1`, go to DONE; otherwise increment `row`, clear `pos`, and return to RUN.
- DONE: pulse `o_frame_done` for one cycle, then go to IDLE.
- Each request pushes a tag into a 1-deep pipeline: {discard, row_last}. On `buf_data_vld`:
  - `o_win_vld = !discard_q`
  - `o_row_last = row_last_q & !discard_q`
- `start` outside IDLE is ignored.
- Counters are unsigned, `ROW_WIDTH` bits, with no wrap inside a legal frame.

## Timing
- Buffer read latency is 1 cycle: `buf_data_vld` follows `buf_rd_req` by exactly one cycle. `o_win_vld` is combinational from `buf_data_vld` and the tag register.
- `start` in cycle t gives `o_busy` high at t+1. The first `buf_rd_req` is possible at t+1.
- Sustained throughput is one window per cycle when `eff` stays `>= NUM_RDATA` and `ds_ready` stays high.
- `ds_ready` low drops `buf_rd_req` in the same cycle (RUN only). The in-flight read still completes.
- Reset values: `buf_rd_req`=0, `o_win_vld`=0, `o_row_last`=0, `o_frame_done`=0, `o_busy`=0, state=IDLE, tags cleared.
- Reset mid-frame takes effect at the next edge: the in-flight tag is dropped and no `o_win_vld` follows.
- Empty buffer (`eff` below threshold): the block stalls in its current state with no request and no error.

## Configuration
- `INPUT_BUFFER_CTRL_ERR_EN` defined: adds a sticky output `o_err`, reset 0, cleared only by `rst`. It sets on any of:
  - `buf_data_vld` with no request issued in the previous cycle
  - `start` while busy
  - a rejected config
- Not defined: no `o_err` port. These conditions are silently ignored.

## Test plan
- W=5, H=1, buffer pre-filled with 5 entries, `ds_ready`=1 → 3 consecutive `o_win_vld`, the 3rd with `o_row_last`; 2 discard reads with no `o_win_vld`; `o_frame_done` 1 cycle after the last discard.
- W=4, H=3, entries trickled 1 per 2 cycles → 2 windows per row, 6 windows in total; `buf_rd_req` is never issued with `eff < 3` in RUN.
- W=8, H=1, `ds_ready` toggled 0/1 every cycle → exactly 6 windows, no duplicate and no lost window.
- `rst` asserted 2 cycles into RUN (W=6, H=2) → the next cycle shows all outputs 0 and state IDLE; a new `start` restarts cleanly.
- `cfg_row_len`=2 with `start` → stays idle, `o_busy`=0; with `INPUT_BUFFER_CTRL_ERR_EN`, `o_err`=1.
- `start` pulsed again mid-frame → ignored; frame completes with the original W/H counts.
